// File: rtl/bsg_clk_osc_tune_ctrl_pkg.sv
// Shared widths, FSM state encoding and helpers for the ring-oscillator tuning controller.
package bsg_clk_osc_tune_ctrl_pkg;

    localparam int osc_ctl_width_gp  = 2;
    localparam int osc_ds_width_gp   = 2;
    localparam int osc_code_width_gp = osc_ctl_width_gp + osc_ds_width_gp;

    typedef enum logic [3:0] {
        IDLE,
        APPLY,
        SETTLE,
        MRST,
        WINDOW,
        SAMPLE,
        DECIDE,
        LOCKED,
        FAIL
    } bsg_clk_tune_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bsg_clk_osc_tune_ctrl_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
module bsg_clk_tune_timer #(
    parameter int width_p = 9
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               load_i,
    input  logic [width_p-1:0] val_i,
    output logic               done_o
);

    logic [width_p-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= val_i;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign done_o = (r_cnt == '0);

endmodule

// File: rtl/bsg_clk_osc_tune_ctrl.sv
// Sweeps the oscillator code from fastest to slowest, measuring each against a target window,
// and stops at the first code whose monitor count lands inside [lo, hi].
module bsg_clk_osc_tune_ctrl
    import bsg_clk_osc_tune_ctrl_pkg::*;
#(
    parameter int osc_ctl_width_p  = osc_ctl_width_gp,
    parameter int osc_ds_width_p   = osc_ds_width_gp,
    parameter int cnt_width_p      = 16,
    parameter int settle_cycles_p  = 16,
    parameter int mon_rst_cycles_p = 4,
    parameter int window_cycles_p  = 256
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       start_i,
    input  logic [cnt_width_p-1:0]     target_i,
    input  logic [cnt_width_p-1:0]     tol_i,
    output logic [osc_ctl_width_p-1:0] osc_ctl_o,
    output logic [osc_ds_width_p-1:0]  osc_ds_o,
    output logic                       osc_trigger_o,
    output logic                       mon_reset_o,
    output logic                       mon_sample_o,
    input  logic                       mon_v_i,
    input  logic [cnt_width_p-1:0]     mon_count_i,
    output logic                       busy_o,
    output logic                       locked_o,
    output logic                       fail_o
);

    localparam int code_width_lp = osc_ctl_width_p + osc_ds_width_p;
    localparam int max_cycles_lp = max3(settle_cycles_p, mon_rst_cycles_p, window_cycles_p);
    localparam int tmr_width_lp  = $clog2(max_cycles_lp) + 1;
    localparam logic [code_width_lp-1:0] code_max_lp = '1;

    bsg_clk_tune_state_e      r_state, w_next;
    logic [code_width_lp-1:0] r_code;
    logic [cnt_width_p-1:0]   r_lo, r_hi, r_cnt;
    logic                     r_locked, r_fail;

    logic                     w_start, w_lock, w_step, w_give_up;
    logic                     w_tmr_load, w_tmr_done;
    logic [tmr_width_lp-1:0]  w_tmr_val;
    logic [cnt_width_p:0]     w_sum;
    logic [cnt_width_p-1:0]   w_lo, w_hi;
    logic                     w_in_range, w_over_hi;

    // Saturating bounds: lo floors at zero, hi clamps to all-ones on carry out.
    assign w_sum      = {1'b0, target_i} + {1'b0, tol_i};
    assign w_hi       = w_sum[cnt_width_p] ? '1 : w_sum[cnt_width_p-1:0];
    assign w_lo       = (tol_i >= target_i) ? '0 : (target_i - tol_i);
    assign w_in_range = (r_cnt >= r_lo) && (r_cnt <= r_hi);
    assign w_over_hi  = (r_cnt > r_hi);

    bsg_clk_tune_timer #(.width_p(tmr_width_lp)) u_timer (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .load_i   (w_tmr_load),
        .val_i    (w_tmr_val),
        .done_o   (w_tmr_done)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= IDLE;
        else            r_state <= w_next;
    end

    // The timer is loaded with N-1 on entry so each timed state lasts exactly N cycles.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next     = r_state;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        w_start    = 1'b0;
        w_lock     = 1'b0;
        w_step     = 1'b0;
        w_give_up  = 1'b0;
        case (r_state)
            IDLE, LOCKED, FAIL: begin
                if (start_i) begin
                    w_start = 1'b1;
                    w_next  = APPLY;
                end
            end
            APPLY: begin
                w_next     = SETTLE;
                w_tmr_load = 1'b1;
                w_tmr_val  = tmr_width_lp'(settle_cycles_p - 1);
            end
            SETTLE: if (w_tmr_done) begin
                w_next     = MRST;
                w_tmr_load = 1'b1;
                w_tmr_val  = tmr_width_lp'(mon_rst_cycles_p - 1);
            end
            MRST: if (w_tmr_done) begin
                w_next     = WINDOW;
                w_tmr_load = 1'b1;
                w_tmr_val  = tmr_width_lp'(window_cycles_p - 1);
            end
            WINDOW: if (w_tmr_done) w_next = SAMPLE;
            SAMPLE: if (mon_v_i)    w_next = DECIDE;
            DECIDE: begin
                if (w_in_range) begin
                    w_lock = 1'b1;
                    w_next = LOCKED;
                end else if (w_over_hi && (r_code != code_max_lp)) begin
                    w_step = 1'b1;
                    w_next = APPLY;
                end else begin
                    w_give_up = 1'b1;
                    w_next    = FAIL;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_code   <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_cnt    <= '0;
            r_locked <= 1'b0;
            r_fail   <= 1'b0;
        end else begin
            if (w_start) begin
                r_code   <= '0;
                r_lo     <= w_lo;
                r_hi     <= w_hi;
                r_locked <= 1'b0;
                r_fail   <= 1'b0;
            end
            if (w_step)    r_code   <= r_code + 1'b1;
            if (w_lock)    r_locked <= 1'b1;
            if (w_give_up) r_fail   <= 1'b1;
            if ((r_state == SAMPLE) && mon_v_i) r_cnt <= mon_count_i;
        end
    end

    assign osc_ctl_o     = r_code[osc_ctl_width_p-1:0];
    assign osc_ds_o      = r_code[code_width_lp-1:osc_ctl_width_p];
    assign osc_trigger_o = (r_state == APPLY);
    assign mon_reset_o   = (r_state == MRST);
    assign mon_sample_o  = (r_state == SAMPLE);
    assign busy_o        = r_state inside {APPLY, SETTLE, MRST, WINDOW, SAMPLE, DECIDE};
    assign locked_o      = r_locked;
    assign fail_o        = r_fail;

endmodule

// File: tb/tb_bsg_clk_osc_tune_ctrl.sv
// Directed bench: an oscillator/monitor model answers sample requests; a vector table drives full sweeps.
module tb_bsg_clk_osc_tune_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] target_i = '0;
    logic [15:0] tol_i = '0;
    logic [1:0]  osc_ctl_o, osc_ds_o;
    logic        osc_trigger_o, mon_reset_o, mon_sample_o;
    logic        mon_v_i;
    logic [15:0] mon_count_i;
    logic        busy_o, locked_o, fail_o;

    bsg_clk_osc_tune_ctrl dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .start_i      (start_i),
        .target_i     (target_i),
        .tol_i        (tol_i),
        .osc_ctl_o    (osc_ctl_o),
        .osc_ds_o     (osc_ds_o),
        .osc_trigger_o(osc_trigger_o),
        .mon_reset_o  (mon_reset_o),
        .mon_sample_o (mon_sample_o),
        .mon_v_i      (mon_v_i),
        .mon_count_i  (mon_count_i),
        .busy_o       (busy_o),
        .locked_o     (locked_o),
        .fail_o       (fail_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          mode;       // 0: count = 200-20*code, 1: constant count
        logic [15:0] cnt;
        logic [15:0] target;
        logic [15:0] tol;
        int          delay;      // SAMPLE cycles before mon_v_i
        bit          spur;       // drive mon_v_i high outside SAMPLE
        bit          poke;       // extra start_i pulses mid-sweep
        bit          exp_locked;
        bit          exp_fail;
        int          exp_code;
        int          exp_trigs;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;

    // Oscillator + monitor model state
    int          g_mode = 0;
    logic [15:0] g_const = '0;
    int          g_delay = 1;
    bit          g_spur = 1'b0;
    int          cyc = 0;
    int          trig_count = 0;
    int          last_trig_cyc = 0;
    int          last_gap = 0;
    int          samp_run = 0;
    int          samp_len_last = 0;
    logic [3:0]  osc_code = '0;

    function automatic logic [15:0] model_count(input logic [3:0] code);
        if (g_mode == 0) return 16'(200 - 20 * int'(code));
        return g_const;
    endfunction

    always @(negedge clk_i) begin
        cyc <= cyc + 1;
        if (osc_trigger_o) begin
            trig_count    <= trig_count + 1;
            osc_code      <= {osc_ds_o, osc_ctl_o};
            last_gap      <= cyc - last_trig_cyc;
            last_trig_cyc <= cyc;
        end
        if (mon_sample_o) begin
            samp_run <= samp_run + 1;
            if (samp_run + 1 >= g_delay) begin
                mon_v_i     <= 1'b1;
                mon_count_i <= model_count(osc_code);
            end else begin
                mon_v_i     <= 1'b0;
                mon_count_i <= 16'd100;
            end
        end else begin
            if (samp_run != 0) samp_len_last <= samp_run;
            samp_run    <= 0;
            mon_v_i     <= g_spur;
            mon_count_i <= 16'd100;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " ctl"}, 32'(osc_ctl_o), 0);
        check({tag, " ds"}, 32'(osc_ds_o), 0);
        check({tag, " trig"}, 32'(osc_trigger_o), 0);
        check({tag, " mon_rst"}, 32'(mon_reset_o), 0);
        check({tag, " mon_smp"}, 32'(mon_sample_o), 0);
        check({tag, " busy"}, 32'(busy_o), 0);
        check({tag, " locked"}, 32'(locked_o), 0);
        check({tag, " fail"}, 32'(fail_o), 0);
    endtask

    task automatic run_sweep(input int idx, input vec_t v);
        int    base;
        int    n;
        string t;
        t       = $sformatf("v%0d", idx);
        g_mode  = v.mode;
        g_const = v.cnt;
        g_delay = v.delay;
        g_spur  = v.spur;
        tick();
        target_i = v.target;
        tol_i    = v.tol;
        base     = trig_count;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        check({t, " start trig"}, 32'(osc_trigger_o), 1);
        check({t, " start busy"}, 32'(busy_o), 1);
        check({t, " start clr"}, {30'd0, locked_o, fail_o}, 0);
        n = 0;
        while (busy_o && n < 20000) begin
            tick();
            n++;
            start_i = v.poke && busy_o && (n % 50 == 7);
        end
        start_i = 1'b0;
        if (n >= 20000) check({t, " timeout"}, 32'(busy_o), 0);
        check({t, " locked"}, 32'(locked_o), 32'(v.exp_locked));
        check({t, " fail"}, 32'(fail_o), 32'(v.exp_fail));
        check({t, " code"}, {28'd0, osc_ds_o, osc_ctl_o}, 32'(v.exp_code));
        check({t, " trigs"}, 32'(trig_count - base), 32'(v.exp_trigs));
        check({t, " smp_len"}, 32'(samp_len_last), 32'(v.delay));
        if (v.exp_trigs >= 2) check({t, " gap"}, 32'(last_gap), 32'(278 + v.delay));
        repeat (3) tick();
        check({t, " hold code"}, {28'd0, osc_ds_o, osc_ctl_o}, 32'(v.exp_code));
        check({t, " hold flags"}, {30'd0, locked_o, fail_o}, {30'd0, v.exp_locked, v.exp_fail});
    endtask

    vec_t vecs[11];

    initial begin
        int base;
        int n;
        //           mode cnt        target     tol     dly spur poke lk fl code trigs
        vecs[0]  = '{0, 16'd0,     16'd100,   16'd5,  1,  1'b0, 1'b0, 1'b1, 1'b0, 5,  6};
        vecs[1]  = '{0, 16'd0,     16'd100,   16'd5,  10, 1'b1, 1'b1, 1'b1, 1'b0, 5,  6};
        vecs[2]  = '{1, 16'd300,   16'd100,   16'd5,  1,  1'b0, 1'b0, 1'b0, 1'b1, 15, 16};
        vecs[3]  = '{1, 16'd90,    16'd100,   16'd5,  1,  1'b0, 1'b0, 1'b0, 1'b1, 0,  1};
        vecs[4]  = '{1, 16'd95,    16'd100,   16'd5,  2,  1'b0, 1'b0, 1'b1, 1'b0, 0,  1};
        vecs[5]  = '{1, 16'd105,   16'd100,   16'd5,  1,  1'b0, 1'b0, 1'b1, 1'b0, 0,  1};
        vecs[6]  = '{1, 16'd106,   16'd100,   16'd5,  1,  1'b0, 1'b0, 1'b0, 1'b1, 15, 16};
        vecs[7]  = '{1, 16'd94,    16'd100,   16'd5,  1,  1'b0, 1'b0, 1'b0, 1'b1, 0,  1};
        vecs[8]  = '{1, 16'd0,     16'd10,    16'd20, 1,  1'b0, 1'b0, 1'b1, 1'b0, 0,  1};
        vecs[9]  = '{1, 16'hFFFF,  16'hFFF0,  16'h20, 1,  1'b0, 1'b0, 1'b1, 1'b0, 0,  1};
        vecs[10] = '{1, 16'hFFCF,  16'hFFF0,  16'h20, 1,  1'b0, 1'b0, 1'b0, 1'b1, 0,  1};

        repeat (3) tick();
        check_idle_outputs("reset");
        reset_n_i = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 11; i++) run_sweep(i, vecs[i]);

        // Asynchronous reset in the middle of code 2's measurement window.
        g_mode  = 0;
        g_delay = 1;
        g_spur  = 1'b0;
        target_i = 16'd100;
        tol_i    = 16'd5;
        base     = trig_count;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        n = 0;
        while ((trig_count - base) < 3 && n < 2000) begin
            tick();
            n++;
        end
        check("rst wait", 32'(trig_count - base), 3);
        repeat (40) tick();
        check("rst pre code", {28'd0, osc_ds_o, osc_ctl_o}, 2);
        check("rst pre busy", 32'(busy_o), 1);
        #1 reset_n_i = 1'b0;
        #1;
        check_idle_outputs("midrst");
        repeat (2) tick();
        reset_n_i = 1'b1;
        base = trig_count;
        repeat (20) tick();
        check("post rst trigs", 32'(trig_count - base), 0);
        check_idle_outputs("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
